// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA controller.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_e;

  // Register index within the 0x06xx window, taken from cpu_addr[3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_DONE_CLR = 1;
  localparam int unsigned CTRL_ABORT    = 3;

  // STATUS read bits
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ABORTED = 2;

endpackage

// File: rtl/dma_ctrl.sv
// Single-channel word copy engine. Shares the data port with the CPU M stage
// and only uses cycles the CPU leaves idle (cpu_mem_busy low).
//
//   state | meaning
//   IDLE  | waiting for START, bus outputs held at 0
//   RD    | reading word at cur_src, waits for a free bus cycle
//   WR    | writing latched word to cur_dst, waits for a free bus cycle
//   FIN   | one-cycle irq, DONE set unless the transfer was aborted
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_dma,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        cpu_mem_busy,
  output logic        dma_req,
  output logic        dma_we,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_wdata,
  input  logic [31:0] dma_rdata,
  output logic        irq
);

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [31:0]      cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             done_q, done_d, aborted_q, aborted_d;

  logic [1:0]  reg_sel;
  logic        reg_wr, ctrl_wr, busy, grant;
  logic        start, abort, done_clr;
  logic [31:0] status;
  logic        unused_addr_bits;

  // Only bits [3:2] select a register; the window decode is done upstream
  assign unused_addr_bits = ^{cpu_addr[31:4], cpu_addr[1:0]};

  assign reg_sel  = cpu_addr[3:2];
  assign reg_wr   = cs_dma & cpu_we;
  assign ctrl_wr  = reg_wr & (reg_sel == REG_CTRL);
  assign busy     = (state_q != IDLE);
  assign grant    = ~cpu_mem_busy;
  assign start    = ctrl_wr & cpu_wdata[CTRL_START] & ~busy;
  assign abort    = ctrl_wr & cpu_wdata[CTRL_ABORT] & ((state_q == RD) | (state_q == WR));
  assign done_clr = ctrl_wr & cpu_wdata[CTRL_DONE_CLR];

  // Status word and combinational register read mux
  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done_q;
    status[STAT_ABORTED] = aborted_q;
    cpu_rdata            = '0;
    case (reg_sel)
      REG_SRC:  cpu_rdata = src_q;
      REG_DST:  cpu_rdata = dst_q;
      REG_LEN:  cpu_rdata = 32'(len_q);
      default:  cpu_rdata = status;
    endcase
  end

  // Register file writes, transfer FSM next state and bus outputs
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    aborted_d = aborted_q;
    done_d    = done_q & ~done_clr;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    irq       = 1'b0;

    if (reg_wr && !busy) begin
      if (reg_sel == REG_SRC) src_d = {cpu_wdata[31:2], 2'b00};
      if (reg_sel == REG_DST) dst_d = {cpu_wdata[31:2], 2'b00};
      if (reg_sel == REG_LEN) len_d = cpu_wdata[LEN_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_src_d = src_q;
          cur_dst_d = dst_q;
          cnt_d     = len_q;
          aborted_d = 1'b0;
          state_d   = (len_q == '0) ? FIN : RD;
        end
      end
      RD: begin
        dma_req  = grant;
        dma_addr = cur_src_q;
        if (grant) begin
          data_d  = dma_rdata;
          state_d = WR;
        end
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end
      end
      WR: begin
        dma_req   = grant;
        dma_we    = 1'b1;
        dma_addr  = cur_dst_q;
        dma_wdata = data_q;
        // A granted write on the abort edge still counts as a completed word
        if (grant) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          cnt_d     = cnt_q - LEN_W'(1);
          state_d   = (cnt_q == LEN_W'(1)) ? FIN : RD;
        end
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end
      end
      default: begin
        irq     = 1'b1;
        if (!aborted_q) done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Testbench for dma_ctrl: register table, directed transfers and randomized
// transfers checked against an operation-level copy model.
`timescale 1ns/1ps
module tb_dma_ctrl;
  import dma_pkg::*;

  localparam int LEN_W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_dma = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_mem_busy = 1'b0;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        irq;

  logic [31:0] mem     [0:1023];
  logic [31:0] exp_mem [0:1023];

  int n_checks = 0;
  int n_pass   = 0;

  dma_ctrl #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_dma       (cs_dma),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_mem_busy (cpu_mem_busy),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_rdata    (dma_rdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  assign dma_rdata = mem[dma_addr[11:2]];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] idx, input logic [31:0] d);
    cs_dma    = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0600 | (32'(idx) << 2);
    cpu_wdata = d;
    tick();
    cs_dma    = 1'b0;
    cpu_we    = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] idx, output logic [31:0] d);
    cs_dma   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0600 | (32'(idx) << 2);
    #1;
    d        = cpu_rdata;
    cs_dma   = 1'b0;
  endtask

  // Programs and runs one transfer. The model walks a list of 2n bus operations
  // (read src+4i, write dst+4i); each cycle with the CPU idle consumes one
  // operation. An optional CTRL write lands in cycle ctrl_k after START; if it
  // carries ABORT the transfer ends after that cycle's operation.
  task automatic run_transfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                              input int n, input logic [63:0] busy_mask, input int ctrl_k,
                              input logic [31:0] ctrl_val, input logic [31:0] start_val,
                              input logic [31:0] exp_status);
    int          o, k, errs;
    bit          stop, abort_now;
    logic [31:0] hold, exp_addr, rd;
    cpu_write(REG_SRC, src);
    cpu_write(REG_DST, dst);
    cpu_write(REG_LEN, 32'(n));
    for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
    hold = '0;
    cpu_write(REG_CTRL, start_val);
    o = 0; k = 0; stop = 0;
    while (!stop) begin
      cpu_mem_busy = (k < 64) ? busy_mask[k] : 1'b0;
      abort_now = 0;
      if (k == ctrl_k) begin
        cs_dma    = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0600 | (32'(REG_CTRL) << 2);
        cpu_wdata = ctrl_val;
        abort_now = ctrl_val[CTRL_ABORT];
      end
      #2;
      check($sformatf("%s irq_low c%0d", tag, k), irq, 0);
      check($sformatf("%s req c%0d", tag, k), dma_req, !cpu_mem_busy);
      if (!cpu_mem_busy) begin
        exp_addr = ((o % 2) == 1) ? dst + 32'(4 * (o / 2)) : src + 32'(4 * (o / 2));
        check($sformatf("%s addr c%0d", tag, k), dma_addr, exp_addr);
        check($sformatf("%s we c%0d", tag, k), dma_we, ((o % 2) == 1));
        if ((o % 2) == 1) begin
          check($sformatf("%s wdata c%0d", tag, k), dma_wdata, hold);
          exp_mem[exp_addr[11:2]] = hold;
          if (dma_req && dma_we) mem[dma_addr[11:2]] = dma_wdata;
        end else begin
          hold = exp_mem[exp_addr[11:2]];
        end
        o++;
      end
      if (o == 2 * n || abort_now) stop = 1;
      tick();
      cs_dma = 1'b0;
      cpu_we = 1'b0;
      cpu_mem_busy = 1'b0;
      k++;
    end
    #2;
    check($sformatf("%s irq_fin", tag), irq, 1);
    check($sformatf("%s req_fin", tag), dma_req, 0);
    tick();
    #2;
    check($sformatf("%s irq_after", tag), irq, 0);
    cpu_read(REG_CTRL, rd);
    check($sformatf("%s status", tag), rd, exp_status);
    errs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) errs++;
    check($sformatf("%s mem_mismatches", tag), 32'(errs), 0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [10];

  initial begin
    logic [31:0] rd, rsrc, rdst;
    logic [63:0] bm;
    int          n, ck;
    bit          ab;

    vecs[0] = '{1'b0, REG_SRC,  32'h0,          32'h0};
    vecs[1] = '{1'b0, REG_DST,  32'h0,          32'h0};
    vecs[2] = '{1'b0, REG_LEN,  32'h0,          32'h0};
    vecs[3] = '{1'b0, REG_CTRL, 32'h0,          32'h0};
    vecs[4] = '{1'b1, REG_SRC,  32'h1234_5677,  32'h1234_5674};
    vecs[5] = '{1'b1, REG_DST,  32'hFFFF_FFFF,  32'hFFFF_FFFC};
    vecs[6] = '{1'b1, REG_LEN,  32'h0000_01FF,  32'h0000_00FF};
    vecs[7] = '{1'b1, REG_CTRL, 32'h0000_0002,  32'h0};
    vecs[8] = '{1'b1, REG_CTRL, 32'h0000_0008,  32'h0};
    vecs[9] = '{1'b0, REG_SRC,  32'h0,          32'h1234_5674};

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // Reset state
    #2;
    check("rst irq", irq, 0);
    check("rst dma_req", dma_req, 0);
    check("rst dma_we", dma_we, 0);
    check("rst dma_addr", dma_addr, 0);
    check("rst dma_wdata", dma_wdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Register access table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].idx, vecs[i].wdata);
      cpu_read(vecs[i].idx, rd);
      check($sformatf("regvec%0d", i), rd, vecs[i].exp);
    end

    // Uncontended 3-word copy, irq at T+7
    run_transfer("basic", 32'h400, 32'h010, 3, 64'h0, -1, 32'h0, 32'h1, 32'h2);
    cpu_read(REG_SRC, rd);
    check("src_unmodified", rd, 32'h400);
    cpu_read(REG_LEN, rd);
    check("len_unmodified", rd, 32'h3);

    // CPU owns the bus in cycles T+2..T+4
    run_transfer("stall", 32'h400, 32'h010, 3, 64'hE, -1, 32'h0, 32'h1, 32'h2);

    // LEN=0: straight to FIN with no bus cycles
    cpu_write(REG_CTRL, 32'h2);
    cpu_read(REG_CTRL, rd);
    check("done_cleared", rd, 32'h0);
    cpu_write(REG_LEN, 32'h0);
    cpu_write(REG_CTRL, 32'h1);
    #2;
    check("len0 irq", irq, 1);
    check("len0 req", dma_req, 0);
    tick();
    #2;
    check("len0 irq_after", irq, 0);
    cpu_read(REG_CTRL, rd);
    check("len0 status", rd, 32'h2);

    // Second START mid-transfer is ignored
    run_transfer("restart", 32'h100, 32'h900, 4, 64'h0, 3, 32'h1, 32'h1, 32'h2);

    // Clear DONE and start together, then ABORT in the 2nd word's read
    run_transfer("abort", 32'h200, 32'hA00, 3, 64'h0, 2, 32'h8, 32'h3, 32'h4);

    // Randomized transfers, optional abort at a random point
    for (int t = 0; t < 8; t++) begin
      n    = $urandom_range(1, 8);
      rsrc = 32'($urandom_range(0, 255)) << 2;
      rdst = 32'h800 + (32'($urandom_range(0, 240)) << 2);
      bm   = {$urandom, $urandom} & {$urandom, $urandom};
      ab   = ($urandom_range(0, 2) == 0);
      ck   = ab ? $urandom_range(0, 2 * n - 1) : -1;
      run_transfer($sformatf("rand%0d", t), rsrc, rdst, n, bm, ck, 32'h8, 32'h3,
                   ab ? 32'h4 : 32'h2);
    end

    // Reset asserted mid-transfer
    cpu_write(REG_SRC, 32'h40);
    cpu_write(REG_DST, 32'h840);
    cpu_write(REG_LEN, 32'h4);
    cpu_write(REG_CTRL, 32'h1);
    tick();
    tick();
    #2;
    check("midrst req_before", dma_req, 1);
    check("midrst addr_before", dma_addr, 32'h44);
    reset_n = 1'b0;
    #1;
    check("midrst req", dma_req, 0);
    check("midrst we", dma_we, 0);
    check("midrst addr", dma_addr, 0);
    check("midrst irq", irq, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'(i), rd);
      check($sformatf("midrst reg%0d", i), rd, 32'h0);
    end
    tick();
    #2;
    check("midrst idle_req", dma_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
